// File: rtl/rb_pkg.sv
// Shared definitions for the rhythm-game judgement path.
// Provides lane counts, the per-player lane masks, the combo ceiling,
// the lane state encoding and a popcount helper for hit vectors.
package rb_pkg;

    localparam int         NUM_LANES = 8;
    localparam logic [7:0] P1_LANES  = 8'h0F;
    localparam logic [7:0] P2_LANES  = 8'hF0;
    localparam logic [6:0] COMBO_MAX = 7'd99;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } lane_state_t;

    // Number of set bits in an 8-bit lane vector (0..8).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/lane_timer.sv
// Per-lane judgement window.
// Ports:
//   Clk, Reset_n : clock and synchronous active-low reset
//   tick         : timebase pulse that advances the window countdown
//   arm          : accepted note for this lane (only honoured while idle)
//   press        : rising edge of this lane's key
//   armed        : lane has a live window
//   hit          : combinational, press landed inside the window this cycle
//   miss         : combinational, window expires this cycle without a press
module lane_timer
    import rb_pkg::*;
#(
    parameter int WINDOW = 8
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic tick,
    input  logic arm,
    input  logic press,
    output logic armed,
    output logic hit,
    output logic miss
);

    lane_state_t state_reg, state_next;
    logic [7:0]  count_reg, count_next;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        hit        = 1'b0;
        miss       = 1'b0;
        case (state_reg)
            IDLE: begin
                // A press in the accept cycle is not judged: the lane is
                // still idle here, so only the arm takes effect.
                if (arm) begin
                    state_next = ARMED;
                    count_next = 8'(WINDOW);
                end
            end
            ARMED: begin
                // Press is checked first so a press on the final tick
                // counts as a hit rather than a miss.
                if (press) begin
                    hit        = 1'b1;
                    state_next = IDLE;
                end else if (tick) begin
                    if (count_reg == 8'd1) begin
                        miss       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        count_next = count_reg - 8'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
            count_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    assign armed = (state_reg == ARMED);

endmodule

// File: rtl/note_judge.sv
// Hit-judgement stage between the key register and the score counters.
// Ports:
//   Clk, Reset_n        : clock and synchronous active-low reset
//   tick                : timebase pulse for window countdowns
//   keyTrack[7:0]       : held keys; lanes 0-3 are P1, lanes 4-7 are P2
//   note_valid/note_lane/note_ready : note offer handshake from the chart
//   p1_inc, p2_inc      : one-cycle score pulses, at most one per cycle
//   miss[7:0]           : one-cycle per-lane miss pulses
//   armed[7:0]          : lanes with a live window
//   p1_combo, p2_combo  : consecutive-hit counts, saturating at 99
module note_judge
    import rb_pkg::*;
#(
    parameter int WINDOW = 8,
    parameter int PEND_W = 3
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 tick,
    input  logic [NUM_LANES-1:0] keyTrack,
    input  logic                 note_valid,
    input  logic [2:0]           note_lane,
    output logic                 note_ready,
    output logic                 p1_inc,
    output logic                 p2_inc,
    output logic [NUM_LANES-1:0] miss,
    output logic [NUM_LANES-1:0] armed,
    output logic [6:0]           p1_combo,
    output logic [6:0]           p2_combo
);

    localparam int PW = PEND_W + 4;
    localparam logic [PW-1:0] PEND_MAX = PW'((1 << PEND_W) - 1);

    logic [NUM_LANES-1:0] prev_reg;
    logic [NUM_LANES-1:0] press;
    logic [NUM_LANES-1:0] arm_vec;
    logic [NUM_LANES-1:0] hit_vec;
    logic [NUM_LANES-1:0] miss_vec;
    logic [NUM_LANES-1:0] miss_reg;
    logic [1:0]           inc_vec;
    logic [6:0]           combo_vec [2];

    // Key history loads during reset too, so a key held across reset
    // does not look like a fresh press afterwards.
    always_ff @(posedge Clk) begin
        prev_reg <= keyTrack;
    end

    assign press      = keyTrack & ~prev_reg;
    assign note_ready = ~armed[note_lane];

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : gen_lane
            assign arm_vec[gi] = note_valid & note_ready & (note_lane == 3'(gi));

            lane_timer #(
                .WINDOW(WINDOW)
            ) u_lane_timer (
                .Clk    (Clk),
                .Reset_n(Reset_n),
                .tick   (tick),
                .arm    (arm_vec[gi]),
                .press  (press[gi]),
                .armed  (armed[gi]),
                .hit    (hit_vec[gi]),
                .miss   (miss_vec[gi])
            );
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            miss_reg <= '0;
        end else begin
            miss_reg <= miss_vec;
        end
    end

    assign miss = miss_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_player
            localparam logic [7:0] MASK = (gi == 0) ? P1_LANES : P2_LANES;

            logic [3:0]    hit_cnt;
            logic          miss_any;
            logic [PEND_W-1:0] pend_reg, pend_next;
            logic [PW-1:0] pend_sum;
            logic [6:0]    combo_reg, combo_next;
            logic [7:0]    combo_sum;

            assign hit_cnt  = popcount8(hit_vec & MASK);
            assign miss_any = |(miss_vec & MASK);

            // Drain one pending hit per cycle while adding this cycle's
            // new hits; the drain is taken before saturating so a full
            // counter still accepts one new hit.
            always_comb begin
                pend_sum = PW'(pend_reg) + PW'(hit_cnt) - PW'(pend_reg != '0);
                if (pend_sum > PEND_MAX) begin
                    pend_next = PEND_MAX[PEND_W-1:0];
                end else begin
                    pend_next = pend_sum[PEND_W-1:0];
                end
            end

            always_comb begin
                combo_sum = {1'b0, combo_reg} + 8'(hit_cnt);
                if (miss_any) begin
                    combo_next = 7'd0;
                end else if (combo_sum > {1'b0, COMBO_MAX}) begin
                    combo_next = COMBO_MAX;
                end else begin
                    combo_next = combo_sum[6:0];
                end
            end

            always_ff @(posedge Clk) begin
                if (!Reset_n) begin
                    pend_reg  <= '0;
                    combo_reg <= 7'd0;
                end else begin
                    pend_reg  <= pend_next;
                    combo_reg <= combo_next;
                end
            end

            assign inc_vec[gi]   = (pend_reg != '0);
            assign combo_vec[gi] = combo_reg;
        end
    endgenerate

    assign p1_inc   = inc_vec[0];
    assign p2_inc   = inc_vec[1];
    assign p1_combo = combo_vec[0];
    assign p2_combo = combo_vec[1];

endmodule

// File: tb/tb_note_judge.sv
// Directed bench for note_judge: hit, burst, expiry, backpressure,
// press/expiry collision, reset mid-window and combo saturation.
module tb_note_judge;

    logic       Clk;
    logic       Reset_n;
    logic       tick;
    logic [7:0] keyTrack;
    logic       note_valid;
    logic [2:0] note_lane;
    logic       note_ready;
    logic       p1_inc;
    logic       p2_inc;
    logic [7:0] miss;
    logic [7:0] armed;
    logic [6:0] p1_combo;
    logic [6:0] p2_combo;

    int checks;
    int errors;
    int exp_combo;

    note_judge #(
        .WINDOW(8),
        .PEND_W(3)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .tick      (tick),
        .keyTrack  (keyTrack),
        .note_valid(note_valid),
        .note_lane (note_lane),
        .note_ready(note_ready),
        .p1_inc    (p1_inc),
        .p2_inc    (p2_inc),
        .miss      (miss),
        .armed     (armed),
        .p1_combo  (p1_combo),
        .p2_combo  (p2_combo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end else begin
            $display("ok   %s: %0d", tag, act);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic offer(input int lane);
        note_valid = 1'b1;
        note_lane  = 3'(lane);
        cyc();
        note_valid = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        Reset_n    = 1'b0;
        tick       = 1'b0;
        keyTrack   = 8'h00;
        note_valid = 1'b0;
        note_lane  = 3'd0;
        cyc();
        cyc();
        check("rst_armed", 32'(armed), 32'h00);
        check("rst_miss", 32'(miss), 32'h00);
        check("rst_p1_inc", 32'(p1_inc), 32'd0);
        check("rst_p2_inc", 32'(p2_inc), 32'd0);
        check("rst_p1_combo", 32'(p1_combo), 32'd0);
        check("rst_p2_combo", 32'(p2_combo), 32'd0);
        Reset_n = 1'b1;
        cyc();

        // Hit on lane 2 after 3 ticks.
        offer(2);
        check("hit_armed2", 32'(armed), 32'h04);
        repeat (3) do_tick();
        keyTrack[2] = 1'b1;
        check("hit_no_inc_yet", 32'(p1_inc), 32'd0);
        cyc();
        check("hit_p1_inc", 32'(p1_inc), 32'd1);
        check("hit_p1_combo", 32'(p1_combo), 32'd1);
        check("hit_armed_clr", 32'(armed), 32'h00);
        check("hit_no_miss", 32'(miss), 32'h00);
        keyTrack[2] = 1'b0;
        cyc();
        check("hit_inc_one_cycle", 32'(p1_inc), 32'd0);

        // Burst on P1 lanes 0-3: four hits metered over four cycles.
        for (int l = 0; l < 4; l++) offer(l);
        check("burst_armed", 32'(armed), 32'h0F);
        keyTrack = keyTrack | 8'h0F;
        cyc();
        check("burst_p1_combo", 32'(p1_combo), 32'd5);
        keyTrack = keyTrack & 8'hF0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("burst_p1_inc_%0d", k), 32'(p1_inc), 32'd1);
            check($sformatf("burst_p2_inc_%0d", k), 32'(p2_inc), 32'd0);
            cyc();
        end
        check("burst_p1_inc_end", 32'(p1_inc), 32'd0);
        check("burst_p2_combo", 32'(p2_combo), 32'd0);

        // Build P2 combo to 5, then let lane 5 expire.
        for (int l = 4; l < 8; l++) offer(l);
        keyTrack = keyTrack | 8'hF0;
        cyc();
        keyTrack = keyTrack & 8'h0F;
        repeat (4) cyc();
        offer(4);
        keyTrack[4] = 1'b1;
        cyc();
        keyTrack[4] = 1'b0;
        cyc();
        check("exp_p2_combo_pre", 32'(p2_combo), 32'd5);
        offer(5);
        repeat (7) do_tick();
        check("exp_no_miss_early", 32'(miss), 32'h00);
        check("exp_still_armed", 32'(armed), 32'h20);
        do_tick();
        check("exp_miss5", 32'(miss), 32'h20);
        check("exp_p2_combo_clr", 32'(p2_combo), 32'd0);
        check("exp_armed_clr", 32'(armed), 32'h00);
        check("exp_p2_inc", 32'(p2_inc), 32'd0);
        cyc();
        check("exp_miss_one_cycle", 32'(miss), 32'h00);

        // Backpressure on lane 1.
        offer(1);
        note_valid = 1'b1;
        note_lane  = 3'd1;
        #1;
        check("bp_ready_low", 32'(note_ready), 32'd0);
        cyc();
        check("bp_not_accepted", 32'(armed), 32'h02);
        keyTrack[1] = 1'b1;
        cyc();
        check("bp_hit_inc", 32'(p1_inc), 32'd1);
        check("bp_armed_clr", 32'(armed), 32'h00);
        check("bp_ready_high", 32'(note_ready), 32'd1);
        cyc();
        note_valid = 1'b0;
        check("bp_accepted", 32'(armed), 32'h02);
        keyTrack[1] = 1'b0;
        cyc();
        keyTrack[1] = 1'b1;
        cyc();
        keyTrack[1] = 1'b0;
        cyc();
        check("bp_p1_combo", 32'(p1_combo), 32'd7);

        // Collision on lane 6: press and final tick together.
        offer(6);
        repeat (7) do_tick();
        keyTrack[6] = 1'b1;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        check("col_p2_inc", 32'(p2_inc), 32'd1);
        check("col_no_miss", 32'(miss), 32'h00);
        check("col_p2_combo", 32'(p2_combo), 32'd1);
        keyTrack[6] = 1'b0;
        cyc();
        check("col_no_miss_late", 32'(miss), 32'h00);

        // Reset mid-window with key 3 held and a pending P1 hit.
        keyTrack[3] = 1'b1;
        cyc();
        check("stray_not_armed", 32'(armed), 32'h00);
        check("stray_combo", 32'(p1_combo), 32'd7);
        offer(3);
        offer(0);
        keyTrack[0] = 1'b1;
        cyc();
        check("rmw_pending_inc", 32'(p1_inc), 32'd1);
        Reset_n = 1'b0;
        cyc();
        Reset_n = 1'b1;
        check("rmw_armed", 32'(armed), 32'h00);
        check("rmw_p1_inc", 32'(p1_inc), 32'd0);
        check("rmw_p1_combo", 32'(p1_combo), 32'd0);
        check("rmw_p2_combo", 32'(p2_combo), 32'd0);
        for (int k = 0; k < 10; k++) begin
            do_tick();
            check($sformatf("rmw_post_miss_%0d", k), 32'(miss), 32'h00);
            check($sformatf("rmw_post_inc_%0d", k), 32'(p1_inc), 32'd0);
        end
        offer(3);
        cyc();
        check("rmw_held_no_edge", 32'(armed), 32'h08);
        keyTrack[3] = 1'b0;
        cyc();
        keyTrack[3] = 1'b1;
        cyc();
        check("rmw_fresh_press", 32'(p1_inc), 32'd1);
        keyTrack[3] = 1'b0;
        keyTrack[0] = 1'b0;
        cyc();
        check("rmw_combo_after", 32'(p1_combo), 32'd1);

        // Combo saturation over 101 further hits on lane 0.
        exp_combo = 1;
        for (int n = 0; n < 101; n++) begin
            offer(0);
            keyTrack[0] = 1'b1;
            cyc();
            keyTrack[0] = 1'b0;
            exp_combo = (exp_combo + 1 > 99) ? 99 : exp_combo + 1;
            check($sformatf("sat_combo_%0d", n), 32'(p1_combo), 32'(exp_combo));
        end
        check("sat_final", 32'(p1_combo), 32'd99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
